// File: rtl/inst_encoder_if.sv
// inst_encoder_if: request handshake between a loader sequencer and
// the instruction encoder (decoded fields in, ready back).
interface inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op_sel;
    logic [4:0]  reg_dst;
    logic [4:0]  reg_s;
    logic [4:0]  reg_t;
    logic [4:0]  imme;
    logic [9:0]  imme_1;

    modport master (
        output in_valid,
        output op_sel,
        output reg_dst,
        output reg_s,
        output reg_t,
        output imme,
        output imme_1,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  op_sel,
        input  reg_dst,
        input  reg_s,
        input  reg_t,
        input  imme,
        input  imme_1,
        output in_ready
    );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded VMIPS fields into 32-bit words and writes
// them to consecutive instruction-memory addresses, one per request.
module inst_encoder #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    inst_encoder_if.slave     req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done,
    output logic              illegal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_FULL = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LW   = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_done;
    logic              r_illegal;

    logic              w_ready;
    logic              w_accept;
    logic              w_legal;
    logic              w_wr;
    logic [31:0]       w_wdata;
    logic [ADDR_W:0]   w_cnt_inc;
    logic              w_last;
    logic [15:0]       w_imm_sx;

    // ready drops combinationally during reset, clear, and once full
    assign w_ready     = rst_n && !clear && (r_state != S_FULL);
    assign req.in_ready = w_ready;
    assign w_accept    = req.in_valid && w_ready;
    assign w_wr        = w_accept && w_legal;
    assign w_cnt_inc   = r_count + LP_ONE;
    assign w_last      = (w_cnt_inc == LP_DEPTH);
    assign w_imm_sx    = {{6{req.imme_1[9]}}, req.imme_1};

    // pack the request fields into an instruction word; flag bad op_sel
    always_comb begin
        w_legal = 1'b1;
        w_wdata = 32'h0;
        unique case (req.op_sel)
            OP_ADD: w_wdata = {6'b000000, req.reg_s, req.reg_t,
                               req.reg_dst, 5'd0, 6'b100000};
            OP_SUB: w_wdata = {6'b000000, req.reg_s, req.reg_t,
                               req.reg_dst, 5'd0, 6'b100010};
            OP_AND: w_wdata = {6'b000000, req.reg_s, req.reg_t,
                               req.reg_dst, 5'd0, 6'b100100};
            OP_OR:  w_wdata = {6'b000000, req.reg_s, req.reg_t,
                               req.reg_dst, 5'd0, 6'b100101};
            OP_SLL: w_wdata = {6'b000000, 5'd0, req.reg_t,
                               req.reg_dst, req.imme, 6'b000000};
            OP_ADDI: w_wdata = {6'b001000, req.reg_s, req.reg_t,
                                w_imm_sx};
            OP_LW:  w_wdata = {6'b100011, req.reg_s, req.reg_t,
                               w_imm_sx};
            OP_SW:  w_wdata = {6'b101011, req.reg_s, req.reg_t,
                               w_imm_sx};
            default: w_legal = 1'b0;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next state: illegal requests never move the fill pointer
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: if (w_wr) w_state_nxt = w_last ? S_FULL : S_FILL;
                S_FILL: if (w_wr && w_last) w_state_nxt = S_FULL;
                S_FULL: w_state_nxt = S_FULL;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // write port: one-cycle strobe carrying the word and its address
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_done  <= 1'b0;
        end else begin
            r_we   <= w_wr;
            r_done <= w_wr && w_last;
            if (w_wr) begin
                r_addr  <= r_count[ADDR_W-1:0];
                r_wdata <= w_wdata;
            end
        end
    end

    // fill counter, full flag and sticky illegal flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_full    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (clear) begin
            r_count   <= '0;
            r_full    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (w_wr) begin
                r_count <= w_cnt_inc;
                r_full  <= w_last;
            end
            if (w_accept && !w_legal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign full       = r_full;
    assign done       = r_done;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: table-driven stimulus with a write scoreboard for the
// instruction encoder, plus clear / reset corner sequences.
module tb_inst_encoder;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [9:0]  imm;
        logic [31:0] exp;
        bit          legal;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        bit                done;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              done;
    logic              illegal;

    inst_encoder_if bus ();

    inst_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .req        (bus.slave),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .full       (full),
        .done       (done),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_err    = 0;
    wr_t q[$];
    int  m_count   = 0;
    bit  m_full    = 1'b0;
    bit  m_illegal = 1'b0;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // one cycle: check model state, drive inputs, record an accept
    task automatic step(input vec_t v, input bit vld, input bit clr,
                        input bit rstn);
        @(negedge clk);
        chk("count", 32'(count), 32'(m_count));
        chk("full", 32'(full), 32'(m_full));
        chk("illegal", 32'(illegal), 32'(m_illegal));
        rst_n          = rstn;
        clear          = clr;
        bus.in_valid   = vld;
        bus.op_sel     = v.op;
        bus.reg_s      = v.rs;
        bus.reg_t      = v.rt;
        bus.reg_dst    = v.rd;
        bus.imme       = v.sh;
        bus.imme_1     = v.imm;
        #1;
        chk("in_ready", 32'(bus.in_ready),
            32'(rstn && !clr && !m_full));
        if (vld && rstn && !clr && !m_full) begin
            if (v.legal) begin
                q.push_back('{addr: m_count[ADDR_W-1:0], data: v.exp,
                              done: (m_count + 1 == DEPTH)});
                m_count++;
                if (m_count == DEPTH) m_full = 1'b1;
            end else begin
                m_illegal = 1'b1;
            end
        end
        if (clr || !rstn) begin
            m_count   = 0;
            m_full    = 1'b0;
            m_illegal = 1'b0;
        end
    endtask

    // every write must match the oldest expected entry
    always @(negedge clk) begin
        if (imem_we) begin
            if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data %h want none",
                         imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                chk("wr_data", imem_wdata, e.data);
                chk("wr_done", 32'(done), 32'(e.done));
            end
        end else begin
            chk("done_idle", 32'(done), 32'd0);
        end
    end

    initial begin
        vec_t nop;
        tbl[0] = '{4'd0, 5'd1, 5'd2, 5'd3, 5'd5, 10'h155,
                   32'h00221820, 1'b1};
        tbl[1] = '{4'd5, 5'd0, 5'd1, 5'd31, 5'd31, 10'h3FF,
                   32'h2001FFFF, 1'b1};
        tbl[2] = '{4'd4, 5'd7, 5'd2, 5'd4, 5'd3, 10'h2AA,
                   32'h000220C0, 1'b1};
        tbl[3] = '{4'd9, 5'd1, 5'd1, 5'd1, 5'd1, 10'h001,
                   32'h0, 1'b0};
        tbl[4] = '{4'd6, 5'd1, 5'd2, 5'd9, 5'd0, 10'd4,
                   32'h8C220004, 1'b1};
        tbl[5] = '{4'd7, 5'd1, 5'd2, 5'd9, 5'd0, 10'd8,
                   32'hAC220008, 1'b1};
        tbl[6] = '{4'd1, 5'd4, 5'd5, 5'd6, 5'd0, 10'h0,
                   32'h00853022, 1'b1};
        tbl[7] = '{4'd2, 5'd7, 5'd8, 5'd9, 5'd0, 10'h0,
                   32'h00E84824, 1'b1};
        tbl[8] = '{4'd3, 5'd31, 5'd31, 5'd31, 5'd0, 10'h0,
                   32'h03FFF825, 1'b1};
        nop = tbl[0];

        step(nop, 1'b1, 1'b0, 1'b0);
        step(nop, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);

        for (int i = 0; i < 9; i++) step(tbl[i], 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(nop, 1'b1, 1'b0, 1'b1);

        step(nop, 1'b1, 1'b1, 1'b1);
        step(nop, 1'b0, 1'b0, 1'b1);
        step(tbl[0], 1'b1, 1'b0, 1'b1);
        step(tbl[6], 1'b1, 1'b0, 1'b1);
        step(nop, 1'b1, 1'b1, 1'b1);
        step(nop, 1'b0, 1'b0, 1'b1);

        step(tbl[3], 1'b1, 1'b0, 1'b1);
        step(tbl[4], 1'b1, 1'b0, 1'b1);
        step(tbl[5], 1'b1, 1'b0, 1'b1);
        step(nop, 1'b1, 1'b0, 1'b0);
        step(tbl[8], 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(nop, 1'b0, 1'b0, 1'b1);

        @(negedge clk);
        #1;
        chk("q_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
